// File: rtl/sort_pkg.sv
// sort_pkg: shared types and helpers for the sort_engine block.
//   state_t          - engine FSM encoding (IDLE, SORT, DONE)
//   cmp_swap_needed  - strict compare used by every compare-exchange cell
//   MAX_N / MAX_PW   - bounds on element count and phase-counter width
//   MAX_WIDTH        - widest element the compare helper handles
// Optional feature macro used by the block: SORT_ENGINE_INDEX_EN.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Element count is legal in 2..64, so the phase counter never needs
  // more than MAX_PW bits (it has to hold the value N itself).
  localparam int MAX_N     = 64;
  localparam int MAX_PW    = $clog2(MAX_N + 1);
  localparam int MAX_WIDTH = 64;

  // Strict compare: equal elements never swap, which keeps the sort stable.
  function automatic logic cmp_swap_needed(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 descend
  );
    return descend ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: one combinational compare-exchange cell.
//   a_i, b_i       - element pair at positions k, k+1 (unsigned, WIDTH bits)
//   descend_i      - 0 = ascending, 1 = descending
//   a_idx_i/b_idx_i- original positions of the pair (SORT_ENGINE_INDEX_EN only)
//   lo_o, hi_o     - ordered pair to be written back to positions k, k+1
//   lo_idx_o/hi_idx_o - positions travelling with lo_o/hi_o (SORT_ENGINE_INDEX_EN only)
//   swapped_o      - high when the pair is out of order and gets exchanged
// WIDTH must not exceed sort_pkg::MAX_WIDTH.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef SORT_ENGINE_INDEX_EN
  ,
  parameter int IW = 3
`endif
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             descend_i,
`ifdef SORT_ENGINE_INDEX_EN
  input  logic [IW-1:0]    a_idx_i,
  input  logic [IW-1:0]    b_idx_i,
  output logic [IW-1:0]    lo_idx_o,
  output logic [IW-1:0]    hi_idx_o,
`endif
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             swapped_o
);

  logic [MAX_WIDTH-1:0] a_ext;
  logic [MAX_WIDTH-1:0] b_ext;

  assign a_ext     = MAX_WIDTH'(a_i);
  assign b_ext     = MAX_WIDTH'(b_i);
  assign swapped_o = cmp_swap_needed(a_ext, b_ext, descend_i);

  assign lo_o = swapped_o ? b_i : a_i;
  assign hi_o = swapped_o ? a_i : b_i;

`ifdef SORT_ENGINE_INDEX_EN
  assign lo_idx_o = swapped_o ? b_idx_i : a_idx_i;
  assign hi_idx_o = swapped_o ? a_idx_i : b_idx_i;
`endif

endmodule

// File: rtl/sort_engine.sv
// sort_engine: handshaked odd-even transposition sorter, one phase per cycle,
// with early termination once two consecutive phases perform no swap.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake; data_in + descend sampled at accept
//   data_in [N]         - unsigned WIDTH-bit elements
//   descend             - 0 = ascending, 1 = descending
//   out_valid/out_ready - output handshake; result held while out_ready is low
//   data_out [N]        - sorted vector (registered)
//   phases              - phases executed for the current result (2..N)
//   busy                - high while sorting
//   idx_out [N]         - original input position of each output element
//                         (present only when SORT_ENGINE_INDEX_EN is defined)
// Legal N is 2..64; WIDTH up to 64.
module sort_engine
  import sort_pkg::*;
#(
  parameter int N     = 6,
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in [N],
  input  logic             descend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out [N],
  output logic [PW-1:0]    phases,
`ifdef SORT_ENGINE_INDEX_EN
  output logic [$clog2(N)-1:0] idx_out [N],
`endif
  output logic             busy
);

`ifdef SORT_ENGINE_INDEX_EN
  localparam int IW = $clog2(N);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q [N];
  logic [WIDTH-1:0] vec_d [N];
  logic [WIDTH-1:0] vec_ph [N];        // working vector after this cycle's phase
  logic [WIDTH-1:0] dout_q [N];
  logic [WIDTH-1:0] dout_d [N];
  logic             desc_q, desc_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    phases_q, phases_d;
  logic             clean_q, clean_d;  // previous phase performed no swap
  logic             phase_swap;
  logic             last_phase;

  logic [WIDTH-1:0] cell_lo [N-1];
  logic [WIDTH-1:0] cell_hi [N-1];
  logic             cell_sw [N-1];

`ifdef SORT_ENGINE_INDEX_EN
  logic [IW-1:0] idx_q [N];
  logic [IW-1:0] idx_d [N];
  logic [IW-1:0] idx_ph [N];
  logic [IW-1:0] iout_q [N];
  logic [IW-1:0] iout_d [N];
  logic [IW-1:0] cell_lo_idx [N-1];
  logic [IW-1:0] cell_hi_idx [N-1];
`endif

  // One cell per adjacent pair; the phase parity picks which cells apply.
  for (genvar gi = 0; gi < N - 1; gi++) begin : g_cell
    sort_cmp_swap #(
      .WIDTH (WIDTH)
`ifdef SORT_ENGINE_INDEX_EN
      ,
      .IW    (IW)
`endif
    ) u_cell (
      .a_i       (vec_q[gi]),
      .b_i       (vec_q[gi+1]),
      .descend_i (desc_q),
`ifdef SORT_ENGINE_INDEX_EN
      .a_idx_i   (idx_q[gi]),
      .b_idx_i   (idx_q[gi+1]),
      .lo_idx_o  (cell_lo_idx[gi]),
      .hi_idx_o  (cell_hi_idx[gi]),
`endif
      .lo_o      (cell_lo[gi]),
      .hi_o      (cell_hi[gi]),
      .swapped_o (cell_sw[gi])
    );
  end

  // Even phase writes back cells 0,2,4..; odd phase cells 1,3,5..
  // Cells of one parity touch disjoint positions, so there is no overlap.
  // An element with no partner in this phase keeps its value.
  always_comb begin
    vec_ph     = vec_q;
`ifdef SORT_ENGINE_INDEX_EN
    idx_ph     = idx_q;
`endif
    phase_swap = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      if (k[0] == cnt_q[0]) begin
        vec_ph[k]   = cell_lo[k];
        vec_ph[k+1] = cell_hi[k];
`ifdef SORT_ENGINE_INDEX_EN
        idx_ph[k]   = cell_lo_idx[k];
        idx_ph[k+1] = cell_hi_idx[k];
`endif
        phase_swap  = phase_swap | cell_sw[k];
      end
    end
  end

  // clean_q is only set after a completed phase, so the early exit can never
  // fire before two phases have run.
  assign last_phase = (cnt_q == PW'(N - 1)) || (!phase_swap && clean_q);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    dout_d   = dout_q;
    desc_d   = desc_q;
    cnt_d    = cnt_q;
    phases_d = phases_q;
    clean_d  = clean_q;
`ifdef SORT_ENGINE_INDEX_EN
    idx_d    = idx_q;
    iout_d   = iout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d   = data_in;
          desc_d  = descend;
          cnt_d   = '0;
          clean_d = 1'b0;
`ifdef SORT_ENGINE_INDEX_EN
          for (int k = 0; k < N; k++) idx_d[k] = IW'(k);
`endif
          state_d = SORT;
        end
      end
      SORT: begin
        vec_d   = vec_ph;
`ifdef SORT_ENGINE_INDEX_EN
        idx_d   = idx_ph;
`endif
        cnt_d   = cnt_q + PW'(1);
        clean_d = !phase_swap;
        if (last_phase) begin
          dout_d   = vec_ph;
`ifdef SORT_ENGINE_INDEX_EN
          iout_d   = idx_ph;
`endif
          phases_d = cnt_q + PW'(1);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      desc_q   <= 1'b0;
      cnt_q    <= '0;
      phases_q <= '0;
      clean_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        vec_q[k]  <= '0;
        dout_q[k] <= '0;
`ifdef SORT_ENGINE_INDEX_EN
        idx_q[k]  <= '0;
        iout_q[k] <= '0;
`endif
      end
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      cnt_q    <= cnt_d;
      phases_q <= phases_d;
      clean_q  <= clean_d;
      vec_q    <= vec_d;
      dout_q   <= dout_d;
`ifdef SORT_ENGINE_INDEX_EN
      idx_q    <= idx_d;
      iout_q   <= iout_d;
`endif
    end
  end

  // Handshake flags are direct decodes of the registered state.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SORT);
  assign out_valid = (state_q == DONE);
  assign data_out  = dout_q;
  assign phases    = phases_q;
`ifdef SORT_ENGINE_INDEX_EN
  assign idx_out   = iout_q;
`endif

endmodule

// File: tb/tb_sort_engine.sv
module tb_sort_engine;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int PW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_in [N];
  logic          descend;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out [N];
  logic [PW-1:0] phases;
  logic          busy;
`ifdef SORT_ENGINE_INDEX_EN
  logic [IW-1:0] idx_out [N];
`endif

  always #5 clk = ~clk;

  sort_engine #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .descend   (descend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .phases    (phases),
`ifdef SORT_ENGINE_INDEX_EN
    .idx_out   (idx_out),
`endif
    .busy      (busy)
  );

  typedef struct packed {
    logic [47:0] din;
    logic        desc;
    logic [47:0] dexp;
    logic [3:0]  pexp;   // 0 = only check 2 <= phases <= N
  } vec_t;

  typedef struct packed {
    logic [47:0] dexp;
    logic [3:0]  pexp;
    logic        ichk;
    logic [17:0] iexp;
  } exp_t;

  exp_t sb[$];
  vec_t tbl [7];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5);
    return {a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [17:0] pki(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5);
    return {a5[2:0], a4[2:0], a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
  endfunction

  function automatic logic [47:0] dout_pk();
    logic [47:0] r;
    for (int k = 0; k < N; k++) r[k*8 +: 8] = data_out[k];
    return r;
  endfunction

  // Independent reference: insertion sort (stable, strict compare).
  function automatic logic [47:0] ref_sort(input logic [47:0] v, input logic d);
    int s [N];
    int t;
    int j;
    logic [47:0] r;
    for (int k = 0; k < N; k++) s[k] = int'(v[k*8 +: 8]);
    for (int k = 1; k < N; k++) begin
      t = s[k];
      j = k - 1;
      while (j >= 0 && (d ? (s[j] < t) : (s[j] > t))) begin
        s[j+1] = s[j];
        j--;
      end
      s[j+1] = t;
    end
    for (int k = 0; k < N; k++) r[k*8 +: 8] = s[k][7:0];
    return r;
  endfunction

  task automatic drive_in(input logic [47:0] v, input logic d);
    for (int k = 0; k < N; k++) data_in[k] = v[k*8 +: 8];
    descend = d;
  endtask

  task automatic run_one(input string tag, input logic [47:0] din, input logic d,
                         input logic [47:0] dexp, input logic [3:0] pexp,
                         input logic ichk, input logic [17:0] iexp, input int bp);
    exp_t        e;
    exp_t        got;
    int          n;
    int          lat;
    logic [47:0] snap_d;
    logic [PW-1:0] snap_p;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_in_ready_wait"}, 64'(in_ready), 64'(1));
    drive_in(din, d);
    in_valid = 1'b1;
    @(posedge clk);
    e.dexp = dexp; e.pexp = pexp; e.ichk = ichk; e.iexp = iexp;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    // changing inputs after accept must not affect the sort
    drive_in({$urandom, 16'($urandom)}, ~d);
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_in_ready_low"}, 64'(in_ready), 64'(0));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_latency"}, 64'(lat), 64'(phases));
    snap_d = dout_pk();
    snap_p = phases;
    for (int c = 0; c < bp; c++) begin
      in_valid = c[0];
      drive_in({$urandom, 16'($urandom)}, c[1]);
      @(posedge clk); #1;
      chk({tag, "_bp_data"}, 64'(dout_pk()), 64'(snap_d));
      chk({tag, "_bp_phases"}, 64'(phases), 64'(snap_p));
      chk({tag, "_bp_in_ready"}, 64'(in_ready), 64'(0));
      chk({tag, "_bp_out_valid"}, 64'(out_valid), 64'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
    end else begin
      got = sb.pop_front();
      chk({tag, "_data"}, 64'(dout_pk()), 64'(got.dexp));
      if (got.pexp != 0) chk({tag, "_phases"}, 64'(phases), 64'(got.pexp));
      else begin
        total++;
        if (phases < 2 || phases > N) begin
          bad++;
          $display("FAIL %s_phases_range: got %0d expected 2..%0d", tag, phases, N);
        end
      end
`ifdef SORT_ENGINE_INDEX_EN
      if (got.ichk) begin
        logic [17:0] ip;
        for (int k = 0; k < N; k++) ip[k*3 +: 3] = idx_out[k];
        chk({tag, "_idx"}, 64'(ip), 64'(got.iexp));
      end
`endif
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready_after"}, 64'(in_ready), 64'(1));
    $display("txn %s: data_out=%h phases=%0d latency=%0d", tag, dout_pk(), phases, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] rv;
    logic        rd;
    tbl[0] = '{pk(5,3,9,1,7,2), 1'b0, pk(1,2,3,5,7,9), 4'd6};
    tbl[1] = '{pk(1,2,3,4,5,6), 1'b0, pk(1,2,3,4,5,6), 4'd2};
    tbl[2] = '{pk(1,2,3,4,5,6), 1'b1, pk(6,5,4,3,2,1), 4'd6};
    tbl[3] = '{pk(8,8,8,8,8,8), 1'b0, pk(8,8,8,8,8,8), 4'd2};
    tbl[4] = '{pk(2,1,3,4,5,6), 1'b0, pk(1,2,3,4,5,6), 4'd3};
    tbl[5] = '{pk(1,2,3,4,6,5), 1'b0, pk(1,2,3,4,5,6), 4'd3};
    tbl[6] = '{pk(0,255,0,255,0,255), 1'b1, pk(255,255,255,0,0,0), 4'd5};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive_in('0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_phases", 64'(phases), 64'(0));
    chk("rst_data_out", 64'(dout_pk()), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_one($sformatf("tbl%0d", i), tbl[i].din, tbl[i].desc, tbl[i].dexp,
              tbl[i].pexp, 1'b0, '0, (i == 0) ? 5 : 0);

    // reset during the second phase discards the partial result
    drive_in(pk(6,5,4,3,2,1), 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_data_out", 64'(dout_pk()), 64'(0));
    chk("midrst_phases", 64'(phases), 64'(0));
    run_one("after_rst", pk(8,8,8,8,8,8), 1'b0, pk(8,8,8,8,8,8), 4'd2, 1'b0, '0, 0);

`ifdef SORT_ENGINE_INDEX_EN
    run_one("index", pk(4,2,4,2,9,0), 1'b0, pk(0,2,2,4,4,9), 4'd6,
            1'b1, pki(5,1,3,0,2,4), 0);
`endif

    for (int i = 0; i < 20; i++) begin
      rv = {$urandom, 16'($urandom)};
      if (i[0]) rv = rv & 48'h0303_0303_0303;  // many duplicates
      rd = i[1];
      run_one($sformatf("rnd%0d", i), rv, rd, ref_sort(rv, rd), 4'd0, 1'b0, '0,
              (i == 3) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Parametrised, handshaked successor to the fixed-pipeline sorter.
- Accepts an N-element vector and sorts it in place with an odd-even transposition network, one compare-exchange phase per cycle.
- Sort direction is selectable per transaction. The sort terminates early once the vector is stable.
- Sits between a producer and a consumer on valid/ready interfaces, with full backpressure on the output side.

Parameters:
- N, 6, element count; legal range 2..64.
- WIDTH, 8, element width in bits (unsigned).
- PW, $clog2(N+1), derived width of the phase counter and the phases output.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a vector.
- in_ready  out  1  engine can accept a vector.
- data_in  in  WIDTH x N  unpacked array [N] of unsigned elements.
- descend  in  1  0 = ascending, 1 = descending; sampled at accept.
- out_valid  out  1  sorted vector available.
- out_ready  in  1  consumer accepts the vector.
- data_out  out  WIDTH x N  sorted vector, registered.
- phases  out  PW  number of phases executed for the current result.
- busy  out  1  high in SORT.

Behaviour:
- Reset values (synchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, data_out all 0, phases=0, internal vector 0.
- State machine uses states IDLE, SORT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch data_in into the working vector and latch descend.
  - Clear phase_cnt and the clean-phase flag, then go to SORT.
- SORT:
  - in_ready=0, busy=1.
  - Each cycle applies one phase:
    - phase_cnt even: pairs (0,1),(2,3)…
    - phase_cnt odd: pairs (1,2),(3,4)…
    - A pair without a partner (last element) is untouched.
  - Swap condition is strict: ascending swaps iff v[k] > v[k+1]; descending swaps iff v[k] < v[k+1]. Equal elements never swap, so the sort is stable.
  - phase_cnt increments every SORT cycle.
  - Exit to DONE after the phase that satisfies either condition:
    - phase_cnt+1 == N, or
    - that phase and the immediately preceding phase both performed zero swaps (requires at least 2 phases).
  - On exit: copy the working vector to data_out, set phases = phases executed, set out_valid=1.
- DONE:
  - out_valid=1; data_out and phases held stable until out_valid&&out_ready.
  - On that handshake: out_valid=0 and return to IDLE; in_ready rises the next cycle, never in the same cycle.
- Latency: out_valid rises exactly P cycles after the accept edge, where P = phases, 2 ≤ P ≤ N. For N=2 the cap always gives P=2.
- in_valid while not in IDLE is ignored; data is not consumed.
- descend and data_in changes after accept have no effect on the current sort.
- Reset asserted in any state, including mid-SORT or DONE with out_ready low: next cycle equals the reset values and the partial result is discarded.
- out_ready while out_valid=0 has no effect.
- Arithmetic is unsigned magnitude compare on WIDTH bits; there is no widening or overflow path.

Optional Feature:
- Macro: SORT_ENGINE_INDEX_EN
- Defined:
  - Adds output idx_out, unpacked [N] of $clog2(N) bits, reset 0.
  - Each element carries its original input position through every swap. idx_out is registered alongside data_out with identical valid/hold timing.
  - Among equal values, idx_out is strictly increasing (stability check).
- Undefined: no idx_out port, no index storage; all other behaviour identical.

Decomposition:
- Package sort_pkg:
  - state_t enum {IDLE, SORT, DONE} (logic [1:0]).
  - Function cmp_swap_needed(a, b, descend).
  - Localparam for the phase counter width helper.
- Sub-module sort_cmp_swap:
  - One combinational compare-exchange cell (a, b, descend, optional index pair in, ordered pair out, swapped flag).
  - Instantiated N-1 times via generate; even/odd phase selects which cells' outputs are written back.

Test Plan:
- N=6, WIDTH=8, ascending, {5,3,9,1,7,2}:
  - data_out={1,2,3,5,7,9}; out_valid exactly phases cycles after accept; phases ≤ 6.
- Presorted {1,2,3,4,5,6}, ascending:
  - data_out unchanged; phases=2; out_valid 2 cycles after accept.
- {1,2,3,4,5,6}, descend=1 (full reversal):
  - data_out={6,5,4,3,2,1}; phases=6 (cap reached).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling in_valid and data_in meanwhile:
  - data_out/phases stable; in_ready=0 throughout; in_ready=1 the cycle after the out handshake.
- Reset mid-SORT (assert rst 1 cycle at second phase):
  - next cycle out_valid=0, data_out all 0, in_ready=1; a fresh vector {8,8,8,8,8,8} then sorts with phases=2.
- With SORT_ENGINE_INDEX_EN, {4,2,4,2,9,0} ascending:
  - data_out={0,2,2,4,4,9}, idx_out={5,1,3,0,2,4}.
